// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative signed/unsigned multiply/divide unit with start/done/abort handshake
//
// Purpose: shift-add multiplier and restoring divider sharing one 2*RV-bit
// working accumulator, retiring STEP bits per RUN cycle. Results land in
// lo/hi/div0, which are separate from the working state.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   start, op, a, b       launch request (op: 00 MULU, 01 MULS, 10 DIVU, 11 DIVS)
//   abort                 kill an in-flight operation
//   hi_wr, hi_wdata       software write of hi while not busy
//   busy, done            in-flight flag, one-cycle completion pulse
//   lo, hi, div0          product halves or quotient/remainder, divide-by-zero flag

module muldiv_unit #(
    parameter int RV   = 32,
    parameter int STEP = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [RV-1:0] a,
    input  logic [RV-1:0] b,
    input  logic          abort,
    input  logic          hi_wr,
    input  logic [RV-1:0] hi_wdata,
    output logic          busy,
    output logic          done,
    output logic [RV-1:0] lo,
    output logic [RV-1:0] hi,
    output logic          div0
);

    localparam int N  = RV / STEP;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2*RV-1:0] acc_q, acc_d;
    logic [RV-1:0]   opnd_q, opnd_d;
    logic            is_div_q, is_div_d;
    logic            res_neg_q, res_neg_d;
    logic            rem_neg_q, rem_neg_d;
    logic            dz_q, dz_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [RV-1:0]   lo_q, lo_d;
    logic [RV-1:0]   hi_q, hi_d;
    logic            div0_q, div0_d;

    // Operand magnitudes: op[0] selects signed interpretation for both mul and div.
    logic          a_neg, b_neg;
    logic [RV-1:0] a_mag, b_mag;

    assign a_neg = op[0] & a[RV-1];
    assign b_neg = op[0] & b[RV-1];
    assign a_mag = a_neg ? (~a + 1'b1) : a;
    assign b_mag = b_neg ? (~b + 1'b1) : b;

    // Sign-corrected views of the finished accumulator.
    logic [2*RV-1:0] prod_fix;
    logic [RV-1:0]   quot_fix, rem_fix;

    assign prod_fix = res_neg_q ? (~acc_q + 1'b1) : acc_q;
    assign quot_fix = res_neg_q ? (~acc_q[RV-1:0] + 1'b1) : acc_q[RV-1:0];
    assign rem_fix  = rem_neg_q ? (~acc_q[2*RV-1:RV] + 1'b1) : acc_q[2*RV-1:RV];

    // One RUN cycle of datapath: STEP chained iterations.
    // Multiply: acc = {partial, multiplier}; add multiplicand on lsb, shift right.
    // Divide:   acc = {remainder, dividend/quotient}; shift left, trial-subtract.
    logic [2*RV-1:0] acc_step;
    logic [RV:0]     sum;
    logic [RV:0]     sh;

    always_comb begin
        acc_step = acc_q;
        sum      = '0;
        sh       = '0;
        for (int i = 0; i < STEP; i++) begin
            if (!is_div_q) begin
                sum      = {1'b0, acc_step[2*RV-1:RV]} + (acc_step[0] ? {1'b0, opnd_q} : {(RV+1){1'b0}});
                acc_step = {sum, acc_step[RV-1:1]};
            end else begin
                sh = {acc_step[2*RV-1:RV], acc_step[RV-1]};
                if (sh >= {1'b0, opnd_q}) begin
                    sh       = sh - {1'b0, opnd_q};
                    acc_step = {sh[RV-1:0], acc_step[RV-2:0], 1'b1};
                end else begin
                    acc_step = {sh[RV-1:0], acc_step[RV-2:0], 1'b0};
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        res_neg_d = res_neg_q;
        rem_neg_d = rem_neg_q;
        dz_d      = dz_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        div0_d    = div0_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start && !abort) begin
                    is_div_d  = op[1];
                    res_neg_d = a_neg ^ b_neg;
                    rem_neg_d = a_neg;
                    opnd_d    = b_mag;
                    cnt_d     = CW'(N - 1);
                    if (op[1] && (b == '0)) begin
                        // Divide by zero skips RUN; raw a is parked for hi.
                        dz_d    = 1'b1;
                        acc_d   = {{RV{1'b0}}, a};
                        state_d = S_FIX;
                    end else begin
                        dz_d    = 1'b0;
                        acc_d   = {{RV{1'b0}}, a_mag};
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = acc_step;
                    if (cnt_q == '0) begin
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            S_FIX: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                    if (!is_div_q) begin
                        lo_d   = prod_fix[RV-1:0];
                        hi_d   = prod_fix[2*RV-1:RV];
                        div0_d = 1'b0;
                    end else if (dz_q) begin
                        lo_d   = '1;
                        hi_d   = acc_q[RV-1:0];
                        div0_d = 1'b1;
                    end else begin
                        lo_d   = quot_fix;
                        hi_d   = rem_fix;
                        div0_d = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Only reachable when not busy, so never collides with the FIX load.
        if (hi_wr && !busy_q) begin
            hi_d = hi_wdata;
        end

        busy_d = (state_d == S_RUN) || (state_d == S_FIX);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            lo_q      <= '0;
            hi_q      <= '0;
            div0_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            res_neg_q <= res_neg_d;
            rem_neg_q <= rem_neg_d;
            dz_q      <= dz_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            div0_q    <= div0_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign lo   = lo_q;
    assign hi   = hi_q;
    assign div0 = div0_q;

endmodule
